if_id_fetch_stage: RTL and testbench
====================================

// Module: if_id_fetch_stage
// PURPOSE
//  Fetch stage plus IF/ID pipeline register; sits directly upstream of the data hazard detector.
//  Holds the PC and drives the instruction-memory address.
//  Latches the fetched word and PC+4 into IF/ID, and exposes the Rs/Rt/opcode fields the hazard detector consumes.
//  Consumes the detector's stall outputs and the ID-stage branch/jump redirect, and keeps stall/flush event counters.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_INSTR 32'h0000_0000  word inserted into IF/ID on bubble or flush
//  CNT_W     16             width of the saturating stall/flush counters
// PORTS
//  Clk            in   1      rising-edge clock
//  Rst            in   1      asynchronous reset, active-low
//  Stall_PC       in   1      1 = hold PC (hazard detector PCWrite output; active-high stall)
//  Stall_IFID     in   1      1 = hold IF/ID (hazard detector IF_IDWrite output; active-high stall)
//  BranchTaken    in   1      ID-stage branch resolved taken
//  BranchTarget   in   32     branch target address
//  Jump           in   1      ID-stage unconditional jump
//  JumpTarget     in   32     jump target address
//  Instr_In       in   32     instruction-memory read data for PC_Out (combinational memory)
//  PC_Out         out  32     current PC, drives instruction-memory address
//  IF_ID_Instr    out  32     latched instruction
//  IF_ID_PCPlus4  out  32     latched PC+4
//  IF_ID_Valid    out  1      1 = IF/ID holds a real instruction
//  IF_IDRs        out  5      IF_ID_Instr[25:21]
//  IF_IDRt        out  5      IF_ID_Instr[20:16]
//  OPCode         out  6      IF_ID_Instr[31:26]
//  StallCount     out  CNT_W  cycles with IF/ID held, saturating
//  FlushCount     out  CNT_W  redirects taken, saturating
// BEHAVIOUR
//  Reset (Rst=0, asynchronous):
//   - PC_Out=RESET_PC; IF_ID_Instr=NOP_INSTR; IF_ID_PCPlus4=0; IF_ID_Valid=0; both counters=0.
//   - Asserting Rst mid-stall or mid-redirect discards all pending state.
//  Field outputs: IF_IDRs, IF_IDRt and OPCode are pure slices of IF_ID_Instr; no added latency.
//  Effective controls:
//   - hold_pc   = Stall_PC | Stall_IFID. Stall_IFID=1 always forces a PC hold so no fetched word is lost.
//   - redirect  = (BranchTaken | Jump) & ~Stall_IFID. Redirects are ignored while ID is stalled
//     because the branch operands are not yet valid.
//   - target    = Jump ? JumpTarget : BranchTarget. Jump wins when both are asserted.
//     target[1:0] is forced to 2'b00.
//  Per rising edge, first matching rule applies:
//   1. redirect: PC<=target; IF/ID<=NOP_INSTR; IF_ID_Valid<=0; FlushCount++.
//   2. Stall_IFID: PC holds; IF/ID holds all fields including Valid; StallCount++.
//   3. Stall_PC only: PC holds; IF/ID<=NOP_INSTR; IF_ID_Valid<=0 (bubble; the word is refetched next cycle).
//   4. otherwise: PC<=PC+4; IF_ID_Instr<=Instr_In; IF_ID_PCPlus4<=PC+4; IF_ID_Valid<=1.
//  Latency: a word fetched at PC appears on IF_ID_Instr one cycle later.
//   - First valid IF/ID is one cycle after Rst deasserts.
//   - A redirect costs exactly one bubble cycle.
//  Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0 with no error flag.
//  Counters: saturate at 2^CNT_W-1 and never wrap. Only reset clears them.
// TESTING
//  T1 reset: Rst low, then release with RESET_PC=0 and Instr_In=32'h8C01_0004
//     -> PC_Out 0,4,8; cycle 1 IF_ID_Instr=8C01_0004, IF_IDRs=0, IF_IDRt=1, OPCode=6'h23, Valid=1.
//  T2 load-use stall: Stall_PC=Stall_IFID=1 for 2 cycles at PC=8
//     -> PC_Out stays 8, IF/ID unchanged, StallCount=2; resumes PC=C.
//  T3 taken branch: BranchTaken=1, BranchTarget=32'h40
//     -> next PC_Out=40, IF_ID_Valid=0, IF_ID_Instr=0, FlushCount=1; cycle after: Valid=1, PCPlus4=44.
//  T4 stall vs. redirect: BranchTaken=1 with Stall_IFID=1
//     -> no redirect, PC held, FlushCount unchanged; BranchTaken with stall low next cycle -> redirect.
//  T5 conflicts and alignment: Stall_PC=1, Stall_IFID=0 -> bubble, PC held.
//     Jump=1 with BranchTaken=1, JumpTarget=32'h103 -> PC=100.
//  T6 boundaries: PC=FFFF_FFFC -> wraps to 0.
//     CNT_W=4 with 20 stall cycles -> StallCount=15.
//     Rst pulsed mid-stall -> all outputs at reset values immediately.

Source files
------------

// File: rtl/if_id_fetch_stage.sv
// Fetch stage with PC register and IF/ID pipeline register feeding the hazard detector.
// Applies hazard stalls and ID-stage redirects, and keeps saturating stall/flush counters.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall_PC,
  input  logic             Stall_IFID,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  input  logic [31:0]      Instr_In,
  output logic [31:0]      PC_Out,
  output logic [31:0]      IF_ID_Instr,
  output logic [31:0]      IF_ID_PCPlus4,
  output logic             IF_ID_Valid,
  output logic [4:0]       IF_IDRs,
  output logic [4:0]       IF_IDRt,
  output logic [5:0]       OPCode,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic [31:0]      pc_p0;
  logic [31:0]      instr_p1;
  logic [31:0]      pcplus4_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic             redirect;
  logic [31:0]      target_raw;
  logic [31:0]      target;
  logic [31:0]      pc_plus4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Operands of an ID-stage branch are not valid while ID is held, so redirects wait.
  assign redirect   = (BranchTaken | Jump) & ~Stall_IFID;
  assign target_raw = Jump ? JumpTarget : BranchTarget;
  assign target     = target_raw & ~32'h0000_0003;
  assign pc_plus4   = pc_p0 + 32'd4;

  // p0 -> p1: PC update and IF/ID capture
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_p0      <= RESET_PC;
      instr_p1   <= NOP_INSTR;
      pcplus4_p1 <= 32'h0000_0000;
      vld_p1     <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else if (redirect) begin
      pc_p0     <= target;
      instr_p1  <= NOP_INSTR;
      vld_p1    <= 1'b0;
      flush_cnt <= sat_inc(flush_cnt);
    end else if (Stall_IFID) begin
      stall_cnt <= sat_inc(stall_cnt);
    end else if (Stall_PC) begin
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else begin
      pc_p0      <= pc_plus4;
      instr_p1   <= Instr_In;
      pcplus4_p1 <= pc_plus4;
      vld_p1     <= 1'b1;
    end
  end

  assign PC_Out        = pc_p0;
  assign IF_ID_Instr   = instr_p1;
  assign IF_ID_PCPlus4 = pcplus4_p1;
  assign IF_ID_Valid   = vld_p1;
  assign IF_IDRs       = instr_p1[25:21];
  assign IF_IDRt       = instr_p1[20:16];
  assign OPCode        = instr_p1[31:26];
  assign StallCount    = stall_cnt;
  assign FlushCount    = flush_cnt;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: directed cycles push expected state,
// a negedge monitor pops and compares against the DUT outputs.
module tb_if_id_fetch_stage;

  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Stall_PC = 1'b0;
  logic          Stall_IFID = 1'b0;
  logic          BranchTaken = 1'b0;
  logic [31:0]   BranchTarget = '0;
  logic          Jump = 1'b0;
  logic [31:0]   JumpTarget = '0;
  logic [31:0]   Instr_In = '0;
  logic [31:0]   PC_Out;
  logic [31:0]   IF_ID_Instr;
  logic [31:0]   IF_ID_PCPlus4;
  logic          IF_ID_Valid;
  logic [4:0]    IF_IDRs;
  logic [4:0]    IF_IDRt;
  logic [5:0]    OPCode;
  logic [CW-1:0] StallCount;
  logic [CW-1:0] FlushCount;

  if_id_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000),
    .CNT_W    (CW)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Stall_PC     (Stall_PC),
    .Stall_IFID   (Stall_IFID),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Instr_In     (Instr_In),
    .PC_Out       (PC_Out),
    .IF_ID_Instr  (IF_ID_Instr),
    .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid  (IF_ID_Valid),
    .IF_IDRs      (IF_IDRs),
    .IF_IDRt      (IF_IDRt),
    .OPCode       (OPCode),
    .StallCount   (StallCount),
    .FlushCount   (FlushCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
    bit          chk_p4;
    logic        vld;
    int          sc;
    int          fc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s[%0d] actual=%h required=%h", name, id, act, req);
  endtask

  // Monitor: one expected record per edge, compared half a cycle later.
  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc",    e.id, PC_Out, e.pc);
      chk("instr", e.id, IF_ID_Instr, e.ins);
      if (e.chk_p4) chk("pcplus4", e.id, IF_ID_PCPlus4, e.p4);
      chk("valid", e.id, {31'd0, IF_ID_Valid}, {31'd0, e.vld});
      chk("rs",    e.id, {27'd0, IF_IDRs}, {27'd0, e.ins[25:21]});
      chk("rt",    e.id, {27'd0, IF_IDRt}, {27'd0, e.ins[20:16]});
      chk("op",    e.id, {26'd0, OPCode},  {26'd0, e.ins[31:26]});
      chk("stallcnt", e.id, {28'd0, StallCount}, e.sc);
      chk("flushcnt", e.id, {28'd0, FlushCount}, e.fc);
    end
  end

  task automatic cyc(input int id, input logic rst, input logic sp, input logic si,
                     input logic bt, input logic [31:0] btgt, input logic j, input logic [31:0] jt,
                     input logic [31:0] iin, input logic [31:0] e_pc, input logic [31:0] e_ins,
                     input logic [31:0] e_p4, input bit cp4, input logic e_v,
                     input int e_sc, input int e_fc);
    exp_t e;
    @(negedge Clk);
    #1;
    Rst = rst; Stall_PC = sp; Stall_IFID = si;
    BranchTaken = bt; BranchTarget = btgt; Jump = j; JumpTarget = jt; Instr_In = iin;
    e.id = id; e.pc = e_pc; e.ins = e_ins; e.p4 = e_p4; e.chk_p4 = cp4;
    e.vld = e_v; e.sc = e_sc; e.fc = e_fc;
    sb.push_back(e);
  endtask

  // Asserts reset between edges so the monitor sees it before any clock edge.
  task automatic rst_pulse(input int id);
    exp_t e;
    @(negedge Clk);
    #1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    e.id = id; e.pc = 32'h0; e.ins = 32'h0; e.p4 = 32'h0; e.chk_p4 = 1'b1;
    e.vld = 1'b0; e.sc = 0; e.fc = 0;
    sb.push_back(e);
  endtask

  initial begin
    // T1 reset and release
    cyc(0,  0,0,0, 0,32'h0, 0,32'h0, 32'h8C01_0004, 32'h0,  32'h0,          32'h0, 1, 0, 0, 0);
    cyc(1,  1,0,0, 0,32'h0, 0,32'h0, 32'h8C01_0004, 32'h4,  32'h8C01_0004,  32'h4, 1, 1, 0, 0);
    cyc(2,  1,0,0, 0,32'h0, 0,32'h0, 32'h8C01_0004, 32'h8,  32'h8C01_0004,  32'h8, 1, 1, 0, 0);
    // T2 load-use stall
    cyc(3,  1,1,1, 0,32'h0, 0,32'h0, 32'h0022_1820, 32'h8,  32'h8C01_0004,  32'h8, 1, 1, 1, 0);
    cyc(4,  1,1,1, 0,32'h0, 0,32'h0, 32'h0022_1820, 32'h8,  32'h8C01_0004,  32'h8, 1, 1, 2, 0);
    cyc(5,  1,0,0, 0,32'h0, 0,32'h0, 32'h0022_1820, 32'hC,  32'h0022_1820,  32'hC, 1, 1, 2, 0);
    // T3 taken branch
    cyc(6,  1,0,0, 1,32'h40, 0,32'h0, 32'hDEAD_BEEF, 32'h40, 32'h0,         32'h0, 0, 0, 2, 1);
    cyc(7,  1,0,0, 0,32'h0, 0,32'h0, 32'h2002_0005, 32'h44, 32'h2002_0005,  32'h44, 1, 1, 2, 1);
    // T4 stall blocks redirect, then redirect proceeds
    cyc(8,  1,1,1, 1,32'h80, 0,32'h0, 32'hDEAD_BEEF, 32'h44, 32'h2002_0005, 32'h44, 1, 1, 3, 1);
    cyc(9,  1,0,0, 1,32'h80, 0,32'h0, 32'hDEAD_BEEF, 32'h80, 32'h0,         32'h0, 0, 0, 3, 2);
    // T5 bubble and jump-over-branch with alignment
    cyc(10, 1,0,0, 0,32'h0, 0,32'h0, 32'h8C43_0008, 32'h84, 32'h8C43_0008,  32'h84, 1, 1, 3, 2);
    cyc(11, 1,1,0, 0,32'h0, 0,32'h0, 32'h8C43_0008, 32'h84, 32'h0,          32'h0, 0, 0, 3, 2);
    cyc(12, 1,0,0, 0,32'h0, 0,32'h0, 32'h8C43_0008, 32'h88, 32'h8C43_0008,  32'h88, 1, 1, 3, 2);
    cyc(13, 1,0,0, 1,32'h200, 1,32'h103, 32'hDEAD_BEEF, 32'h100, 32'h0,     32'h0, 0, 0, 3, 3);
    cyc(14, 1,0,0, 0,32'h0, 0,32'h0, 32'h8C43_0008, 32'h104, 32'h8C43_0008, 32'h104, 1, 1, 3, 3);
    // T6 PC wrap and branch-target alignment
    cyc(15, 1,0,0, 0,32'h0, 1,32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 3, 4);
    cyc(16, 1,0,0, 0,32'h0, 0,32'h0, 32'hAC64_000C, 32'h0,  32'hAC64_000C,  32'h0, 1, 1, 3, 4);
    cyc(17, 1,0,0, 0,32'h0, 0,32'h0, 32'hAC64_000C, 32'h4,  32'hAC64_000C,  32'h4, 1, 1, 3, 4);
    cyc(18, 1,0,0, 1,32'h4E, 0,32'h0, 32'hDEAD_BEEF, 32'h4C, 32'h0,         32'h0, 0, 0, 3, 5);
    // Stall counter saturation at 15
    for (int k = 1; k <= 20; k++)
      cyc(100 + k, 1,1,1, 0,32'h0, 0,32'h0, 32'hDEAD_BEEF, 32'h4C, 32'h0, 32'h0, 0, 0,
          (3 + k > 15) ? 15 : 3 + k, 5);
    // Asynchronous reset mid-stall, then restart
    rst_pulse(200);
    cyc(201, 1,0,0, 0,32'h0, 0,32'h0, 32'h8C01_0004, 32'h4, 32'h8C01_0004, 32'h4, 1, 1, 0, 0);

    @(negedge Clk);
    #2;
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d required=0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
